// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared encodings, FSM states and constants for the pipeline flow controller
package pipe_ctrl_pkg;

    // Instruction types as carried down the pipe; I_LOAD is the only one the stall logic cares about
    typedef enum logic [2:0] {
        I_LOAD  = 3'b000,
        I_LOGIC = 3'b001,
        I_JUMP  = 3'b010,
        R_TYPE  = 3'b011,
        S_TYPE  = 3'b100,
        B_TYPE  = 3'b101,
        J_TYPE  = 3'b110,
        U_TYPE  = 3'b111
    } instr_type_e;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_REDIRECT = 1'b1
    } flow_state_e;

    // addi x0, x0, 0 - what IF/ID holds after a flush
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    // Bubble counter width covers REDIRECT_BUBBLES up to 7
    localparam int BUBBLE_CNT_W = 3;

    function automatic logic is_load(input logic [2:0] itype);
        return itype == I_LOAD;
    endfunction

endpackage

// File: rtl/pipe_flow_ctrl_if.sv
// rtl/pipe_flow_ctrl_if.sv - hazard inputs and stage-control outputs of the pipeline flow controller
interface pipe_flow_ctrl_if #(
    parameter int XLEN = 32
);
    logic            ex_redirect;
    logic [XLEN-1:0] ex_target;
    logic [2:0]      id_ex_type;
    logic [4:0]      id_ex_rd;
    logic [4:0]      if_id_rs1;
    logic [4:0]      if_id_rs2;
    logic            id_use_rs1;
    logic            id_use_rs2;
    logic            imem_rsp_valid;

    logic            pc_en;
    logic            pc_sel;
    logic [XLEN-1:0] pc_target;
    logic            if_id_en;
    logic            if_id_flush;
    logic            id_ex_en;
    logic            id_ex_flush;

    // Core datapath side: presents hazard conditions, consumes stage controls
    modport master (
        output ex_redirect, ex_target, id_ex_type, id_ex_rd, if_id_rs1, if_id_rs2,
               id_use_rs1, id_use_rs2, imem_rsp_valid,
        input  pc_en, pc_sel, pc_target, if_id_en, if_id_flush, id_ex_en, id_ex_flush
    );

    // Flow controller side
    modport slave (
        input  ex_redirect, ex_target, id_ex_type, id_ex_rd, if_id_rs1, if_id_rs2,
               id_use_rs1, id_use_rs2, imem_rsp_valid,
        output pc_en, pc_sel, pc_target, if_id_en, if_id_flush, id_ex_en, id_ex_flush
    );
endinterface

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard compare between EX and ID
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [2:0] ex_type,
    input  logic [4:0] ex_rd,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       use_rs1,
    input  logic       use_rs2,
    output logic       hazard
);

    logic hit_rs1;
    logic hit_rs2;

    // x0 is never written, so a load to x0 cannot create a dependency
    assign hit_rs1 = use_rs1 && (rs1 == ex_rd);
    assign hit_rs2 = use_rs2 && (rs2 == ex_rd);
    assign hazard  = is_load(ex_type) && (ex_rd != 5'd0) && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/pipe_flow_ctrl.sv
// rtl/pipe_flow_ctrl.sv - RV32 pipeline sequencer: PC select, stage enables, flushes; PIPE_PERF_CNT_EN adds event counters
module pipe_flow_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REDIRECT_BUBBLES = 1,
    parameter int XLEN             = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    pipe_flow_ctrl_if.slave bus
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0] perf_redirect_cnt,
    output logic [31:0] perf_loaduse_cnt,
    output logic [31:0] perf_fetchstall_cnt
`endif
);

    localparam logic [BUBBLE_CNT_W-1:0] BUBBLES = BUBBLE_CNT_W'(REDIRECT_BUBBLES);

    flow_state_e             state;
    logic [BUBBLE_CNT_W-1:0] bubble_cnt;
    logic [XLEN-1:0]         target_q;
    logic                    load_use;
    logic                    fetch_ok;
    logic                    take_redirect;

    load_use_detect u_load_use_detect (
        .ex_type (bus.id_ex_type),
        .ex_rd   (bus.id_ex_rd),
        .rs1     (bus.if_id_rs1),
        .rs2     (bus.if_id_rs2),
        .use_rs1 (bus.id_use_rs1),
        .use_rs2 (bus.id_use_rs2),
        .hazard  (load_use)
    );

    // A missing fetch response freezes the whole front end, including the redirect decision
    assign fetch_ok      = bus.imem_rsp_valid;
    assign take_redirect = fetch_ok && (state == ST_RUN) && bus.ex_redirect;

    // Sequencer: capture the redirect target and count off the squash window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            bubble_cnt <= '0;
            target_q   <= '0;
        end else if (fetch_ok) begin
            case (state)
                ST_RUN: begin
                    if (bus.ex_redirect) begin
                        target_q   <= bus.ex_target;
                        bubble_cnt <= BUBBLES;
                        state      <= ST_REDIRECT;
                    end
                end
                ST_REDIRECT: begin
                    bubble_cnt <= bubble_cnt - 1'b1;
                    if (bubble_cnt == BUBBLE_CNT_W'(1)) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    // Stage controls: reset forces the free-running values, then stall > redirect > load-use
    always_comb begin
        bus.pc_en       = 1'b1;
        bus.pc_sel      = 1'b0;
        bus.if_id_en    = 1'b1;
        bus.if_id_flush = 1'b0;
        bus.id_ex_en    = 1'b1;
        bus.id_ex_flush = 1'b0;
        if (!rst_n) begin
            bus.pc_en = 1'b1;
        end else if (!fetch_ok) begin
            bus.pc_en    = 1'b0;
            bus.if_id_en = 1'b0;
            bus.id_ex_en = 1'b0;
        end else if (state == ST_REDIRECT) begin
            // The first squash cycle is the one that loads the target into the PC
            bus.if_id_flush = 1'b1;
            bus.pc_sel      = (bubble_cnt == BUBBLES);
        end else if (bus.ex_redirect) begin
            bus.if_id_flush = 1'b1;
            bus.id_ex_flush = 1'b1;
        end else if (load_use) begin
            bus.pc_en       = 1'b0;
            bus.if_id_en    = 1'b0;
            bus.id_ex_flush = 1'b1;
        end
    end

    assign bus.pc_target = target_q;

`ifdef PIPE_PERF_CNT_EN
    logic loaduse_event;

    assign loaduse_event = fetch_ok && (state == ST_RUN) && !bus.ex_redirect && load_use;

    // Free-running event counters, wrap naturally at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_redirect_cnt   <= '0;
            perf_loaduse_cnt    <= '0;
            perf_fetchstall_cnt <= '0;
        end else begin
            if (take_redirect) perf_redirect_cnt   <= perf_redirect_cnt + 32'd1;
            if (loaduse_event) perf_loaduse_cnt    <= perf_loaduse_cnt + 32'd1;
            if (!fetch_ok)     perf_fetchstall_cnt <= perf_fetchstall_cnt + 32'd1;
        end
    end
`else
    logic unused_redirect;
    assign unused_redirect = take_redirect;
`endif

endmodule
